// File: rtl/mc_bus_pkg.sv
// Shared types for the memory/IO bus controller.
// FSM state encoding, error codes, IO base default, counter helpers.
package mc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_RD  = 2'd1,
    IO_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_TMO   = 2'd2
  } err_e;

  localparam logic [31:0] IO_BASE_DEF = 32'hFFFF0000;
  localparam int          CNT_W       = 8;

  // Terminal count for a wait of n cycles.
  function automatic logic [CNT_W-1:0] tc_of(int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// Wait-state counter: 8-bit up-counter with clear, enable, terminal compare.
// Ports: clk, rst_n, clr_i, en_i, tc_i (compare value), tc_o (count == tc_i).
module mc_wait_cnt
  import mc_bus_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == tc_i);

endmodule

// File: rtl/mc_bus_ctrl.sv
// Bus controller: routes CPU accesses to block RAM or memory-mapped IO.
// Ports: CPU side (req/we/addr/wdata -> rdata/ready/err), RAM side, IO side.
module mc_bus_ctrl
  import mc_bus_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter int          RAM_LAT    = 1,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
  parameter int          IO_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [15:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);

  localparam logic [CNT_W-1:0] RD_TC = tc_of(RAM_LAT);
  localparam logic [CNT_W-1:0] IO_TC = tc_of(IO_TIMEOUT);

  state_e              state_q;
  err_e                code_q;
  logic                we_q;
  logic                io_sel_q;
  logic [31:0]         iodat_q;
  logic [31:0]         rdata_q;
  logic [31:0]         rdata_d;
  logic                ready_q;
  logic                err_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic                ram_we_q;
  logic [31:0]         ram_wdata_q;
  logic                io_req_q;
  logic                io_we_q;
  logic [15:0]         io_addr_q;
  logic [31:0]         io_wdata_q;

  logic                mis;
  logic                hit_io;
  logic                hit_ram;
  logic                cnt_clr;
  logic                cnt_en;
  logic                cnt_tc;
  logic [CNT_W-1:0]    cnt_lim;

  assign mis     = |addr[1:0];
  assign hit_io  = !mis && (addr >= IO_BASE);
  assign hit_ram = !mis && !hit_io;

  always_comb begin
    cnt_clr = (state_q == IDLE);
    cnt_en  = (state_q == RAM_RD) || (state_q == IO_WAIT);
    cnt_lim = (state_q == IO_WAIT) ? IO_TC : RD_TC;
  end

  mc_wait_cnt u_cnt (
    .clk   (clock),
    .rst_n (resetn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_i  (cnt_lim),
    .tc_o  (cnt_tc)
  );

  // RAM data is taken on the ready edge; the address is still held then.
  assign rdata_d = ((code_q != ERR_NONE) || we_q) ? '0 :
                   io_sel_q ? iodat_q : ram_rdata;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      code_q      <= ERR_NONE;
      we_q        <= 1'b0;
      io_sel_q    <= 1'b0;
      iodat_q     <= '0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      io_req_q    <= 1'b0;
      io_we_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (req) begin
            we_q     <= we;
            code_q   <= ERR_NONE;
            io_sel_q <= 1'b0;
            unique case (1'b1)
              mis: begin
                code_q  <= ERR_ALIGN;
                state_q <= DONE;
              end
              hit_io: begin
                io_sel_q   <= 1'b1;
                io_req_q   <= 1'b1;
                io_we_q    <= we;
                io_addr_q  <= addr[15:0];
                io_wdata_q <= wdata;
                state_q    <= IO_WAIT;
              end
              hit_ram: begin
                ram_addr_q <= addr[RAM_AW+1:2];
                if (we) begin
                  ram_we_q    <= 1'b1;
                  ram_wdata_q <= wdata;
                end
                state_q <= RAM_RD;
              end
            endcase
          end
        end
        RAM_RD: begin
          // Writes spend a single cycle here with the strobe up.
          if (we_q) begin
            ram_we_q <= 1'b0;
            state_q  <= DONE;
          end else if (cnt_tc) begin
            state_q <= DONE;
          end
        end
        IO_WAIT: begin
          if (io_ack) begin
            iodat_q  <= io_rdata;
            io_req_q <= 1'b0;
            io_we_q  <= 1'b0;
            state_q  <= DONE;
          end else if (cnt_tc) begin
            code_q   <= ERR_TMO;
            io_req_q <= 1'b0;
            io_we_q  <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          err_q   <= (code_q != ERR_NONE);
          rdata_q <= rdata_d;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign ready     = ready_q;
  assign err       = err_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign io_req    = io_req_q;
  assign io_we     = io_we_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;

endmodule
